// File: rtl/seq_shifter.sv
// Iterative shifter: ROR/SLL/SRA/SRL computed one bit per cycle, with optional
// two-steps-per-cycle mode when SEQ_SHIFTER_DUAL_STEP_EN is defined.
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] In,
  input  logic [CNT_W-1:0] Cnt,
  input  logic [1:0]       Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is high only in IDLE, out_valid only in DONE, so the
  // block holds exactly one op and never accepts and delivers in one cycle.
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [1:0]       op_q, op_d;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d,
                                            input logic [1:0] op);
    case (op)
      2'b00:   step = {d[0], d[WIDTH-1:1]};
      2'b01:   step = {d[WIDTH-2:0], 1'b0};
      2'b10:   step = {d[WIDTH-1], d[WIDTH-1:1]};
      default: step = {1'b0, d[WIDTH-1:1]};
    endcase
  endfunction

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Out       = data_q;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    remain_d = remain_q;
    op_d     = op_q;
    if (flush) begin
      state_d  = IDLE;
      remain_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_d   = In;
            remain_d = Cnt;
            op_d     = Op;
            state_d  = (Cnt != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
`ifdef SEQ_SHIFTER_DUAL_STEP_EN
          if (remain_q >= CNT_W'(2)) begin
            data_d   = step(step(data_q, op_q), op_q);
            remain_d = remain_q - CNT_W'(2);
          end else begin
            data_d   = step(data_q, op_q);
            remain_d = remain_q - CNT_W'(1);
          end
`else
          data_d   = step(data_q, op_q);
          remain_d = remain_q - CNT_W'(1);
`endif
          if (remain_d == '0) state_d = DONE;
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      data_q   <= '0;
      remain_q <= '0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      remain_q <= remain_d;
      op_q     <= op_d;
    end
  end

endmodule
